// File: rtl/branch_unit.sv
// Branch resolve: decides in IDLE, drives registered redirect/flush/clr_flag one cycle later.
// No backpressure: valid_in is ignored during the REDIRECT and SHADOW squash slots.
module branch_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [3:0] br_type,
  input  logic       Z,
  input  logic       N,
  input  logic       C,
  input  logic       V,
  input  logic [7:0] target,
  input  logic [7:0] pc_next,
  output logic       redirect,
  output logic [7:0] pc_target,
  output logic       flush,
  output logic [3:0] clr_flag,
  output logic       stk_err
);

  localparam logic [3:0] BR_JZ   = 4'b0001;
  localparam logic [3:0] BR_JN   = 4'b0010;
  localparam logic [3:0] BR_JC   = 4'b0011;
  localparam logic [3:0] BR_JV   = 4'b0100;
  localparam logic [3:0] BR_LOOP = 4'b0101;
  localparam logic [3:0] BR_JMP  = 4'b0110;
  localparam logic [3:0] BR_CALL = 4'b0111;
  localparam logic [3:0] BR_RET  = 4'b1000;

  typedef enum logic [1:0] {IDLE, REDIRECT, SHADOW} state_t;

  state_t     state;
  logic [7:0] stack [4];
  logic [2:0] cnt;

  logic       decide;
  logic       taken;
  logic       push;
  logic       pop;
  logic       stk_fault;
  logic [3:0] clr_nxt;
  logic [7:0] dest;
  logic [1:0] top_idx;

  assign decide  = valid_in && (state == IDLE);
  // Count 1..4 maps to top entries 0..3; the 2-bit wrap handles count 4.
  assign top_idx = cnt[1:0] - 2'd1;

  always_comb begin
    taken     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    stk_fault = 1'b0;
    clr_nxt   = 4'b0000;
    dest      = target;
    case (br_type)
      BR_JZ:   begin taken = Z; clr_nxt = 4'b0001; end
      BR_JN:   begin taken = N; clr_nxt = 4'b0010; end
      BR_JC:   begin taken = C; clr_nxt = 4'b0100; end
      BR_JV:   begin taken = V; clr_nxt = 4'b1000; end
      BR_LOOP: taken = !Z;
      BR_JMP:  taken = 1'b1;
      BR_CALL: begin
        taken = 1'b1;
        if (cnt == 3'd4) stk_fault = 1'b1;
        else             push      = 1'b1;
      end
      BR_RET: begin
        // An empty-stack return is a fault and falls through as not-taken.
        if (cnt == 3'd0) begin
          stk_fault = 1'b1;
        end else begin
          taken = 1'b1;
          pop   = 1'b1;
          dest  = stack[top_idx];
        end
      end
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && decide && push) stack[cnt[1:0]] <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      redirect  <= 1'b0;
      flush     <= 1'b0;
      clr_flag  <= 4'b0000;
      pc_target <= 8'h00;
      stk_err   <= 1'b0;
      cnt       <= 3'd0;
    end else begin
      redirect <= 1'b0;
      clr_flag <= 4'b0000;
      case (state)
        IDLE: begin
          flush <= 1'b0;
          if (decide) begin
            if (push)      cnt     <= cnt + 3'd1;
            if (pop)       cnt     <= cnt - 3'd1;
            if (stk_fault) stk_err <= 1'b1;
            if (taken) begin
              state     <= REDIRECT;
              redirect  <= 1'b1;
              flush     <= 1'b1;
              pc_target <= dest;
              clr_flag  <= clr_nxt;
            end
          end
        end
        REDIRECT: begin
          state <= SHADOW;
          flush <= 1'b1;
        end
        SHADOW: begin
          state <= IDLE;
          flush <= 1'b0;
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 The port `clk` SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-002 The port `rst` SHALL be an input, 1 bit wide: synchronous, active-low reset, sampled on the rising edge of `clk`.
REQ-003 The port `valid_in` SHALL be an input, 1 bit wide: the EX-stage instruction is valid this cycle.
REQ-004 The port `br_type` SHALL be an input, 4 bits wide: 0000 none, 0001 JZ, 0010 JN, 0011 JC, 0100 JV, 0101 LOOP, 0110 JMP, 0111 CALL, 1000 RET; all other codes are treated as none.
REQ-005 The port `Z` SHALL be an input, 1 bit wide, taken from the ALU CCR[0].
REQ-006 The ports `N`, `C` and `V` SHALL be inputs, 1 bit wide each, taken from the ALU CCR[1], CCR[2] and CCR[3].
REQ-007 The port `target` SHALL be an input, 8 bits wide: the jump/call destination address.
REQ-008 The port `pc_next` SHALL be an input, 8 bits wide: the address of the instruction after the branch, used as the return address.
REQ-009 The port `redirect` SHALL be an output, 1 bit wide: the PC SHALL load `pc_target`.
REQ-010 The port `pc_target` SHALL be an output, 8 bits wide: the redirect address.
REQ-011 The port `flush` SHALL be an output, 1 bit wide: squash the IF/ID and ID/EX pipeline registers.
REQ-012 The port `clr_flag` SHALL be an output, 4 bits wide: a one-cycle pulse that clears the consumed CCR bit, in the same bit order as CCR.
REQ-013 The port `stk_err` SHALL be an output, 1 bit wide: a sticky flag for return-stack overflow or underflow.

Function
REQ-014 Taken conditions SHALL be: JZ when Z=1; JN when N=1; JC when C=1; JV when V=1; LOOP when Z=0 (ALU already produced the decremented count); JMP and CALL always; RET only when the stack is not empty.
REQ-015 The decision SHALL be made in the cycle where valid_in=1 and state=IDLE; all outputs SHALL be registered, giving a latency of 1 cycle from the decision to redirect/flush.
REQ-016 The FSM SHALL have states IDLE, REDIRECT and SHADOW.
REQ-017 In IDLE, a taken branch SHALL move the FSM to REDIRECT; a not-taken branch or none SHALL stay in IDLE with all outputs 0.
REQ-018 In REDIRECT the block SHALL drive redirect=1 and flush=1 and hold pc_target; the next state SHALL be SHADOW unconditionally.
REQ-019 In SHADOW the block SHALL drive redirect=0 and flush=1; the next state SHALL be IDLE.
REQ-020 valid_in SHALL be ignored in REDIRECT and SHADOW, because those are squashed wrong-path slots.
REQ-021 pc_target SHALL be target for JZ, JN, JC, JV, LOOP, JMP and CALL, and the popped top-of-stack for RET; pc_target SHALL hold its value outside REDIRECT.
REQ-022 clr_flag SHALL pulse in REDIRECT only, for a taken conditional: JZ gives 0001, JN gives 0010, JC gives 0100, JV gives 1000; LOOP, JMP, CALL and RET SHALL give 0000.
REQ-023 The return stack SHALL have 4 entries of 8 bits with a 3-bit occupancy count from 0 to 4, LIFO.
REQ-024 A CALL decision SHALL push pc_next and increment the count in the same edge that enters REDIRECT.
REQ-025 A CALL when the count is 4 (full) SHALL drop the push, leave the count and contents unchanged, set stk_err, and still redirect.
REQ-026 A RET decision SHALL pop and decrement the count; pc_target SHALL equal the entry pushed most recently.
REQ-027 A RET when the count is 0 (empty) SHALL set stk_err and be treated as not-taken: no redirect, no flush, state stays IDLE.
REQ-028 stk_err SHALL be sticky and SHALL clear only on reset.
REQ-029 Flag inputs SHALL be sampled only in the decision cycle; flag changes during REDIRECT or SHADOW SHALL have no effect.

Reset
REQ-030 When rst=0 at a rising edge, the FSM SHALL go to IDLE and redirect, flush, clr_flag, pc_target, stk_err and the stack count SHALL all become 0; stack contents are don't-care.
REQ-031 A reset asserted in REDIRECT or SHADOW SHALL abort the sequence; the following cycle SHALL show flush=0 and redirect=0.
REQ-032 The first decision SHALL be possible in the first cycle after rst returns to 1.

Verification
REQ-033 Scenario: JZ with Z=1 and target=8'h40 -> next cycle redirect=1, flush=1, pc_target=40, clr_flag=0001; following cycle flush=1 and redirect=0; then IDLE.
REQ-034 Scenario: JC with C=0 -> no redirect, flush or clr_flag for 3 cycles; a back-to-back JMP in the next cycle is taken normally.
REQ-035 Scenario: LOOP after the ALU computes DEC of 8'h01 (Z=1) -> not taken; LOOP with Z=0 -> taken to target with clr_flag=0000.
REQ-036 Scenario: CALL with pc_next 10, 11, 12, 13, then RET x4 -> pc_target sequence 13, 12, 11, 10; a fifth CALL at count 4 -> stk_err=1 with redirect still asserted.
REQ-037 Scenario: RET with an empty stack -> stk_err=1 and redirect=0; stk_err stays 1 until rst=0.
REQ-038 Scenario: JMP followed by valid_in=1 JMP in both REDIRECT and SHADOW -> both ignored, exactly one redirect; rst=0 during SHADOW -> all outputs 0 next cycle.
